// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of the 16-bit ALU: operand fetch, writeback, lw/sw handshake, beq report.
// Optional macro REG_ZERO_HARDWIRED_EN makes R0 read as zero and discards writes to it.
module alu_issue_stage #(
  parameter int NREGS = 8,
  parameter int IMM_W = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_opcode,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        branch_valid,
  output logic        branch_taken,
  output logic [15:0] branch_offset,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam logic [2:0] OP_RR0 = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_RR2 = 3'b010;
  localparam logic [2:0] OP_RR3 = 3'b011;
  localparam logic [2:0] OP_BEQ = 3'b100;
  localparam logic [2:0] OP_LW = 3'b101;
  localparam logic [2:0] OP_SW = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

  state_t      state, state_nxt;
  logic [15:0] regs [NREGS];
  logic [15:0] ir;
  logic [2:0]  in_op, in_rd, in_rs, in_rt;
  logic [2:0]  ir_op, ir_rd;
  logic [15:0] opnd_a, opnd_b;
  logic        wr_en;
  logic [15:0] wr_data;

  function automatic logic [15:0] rdreg(input logic [2:0] idx);
`ifdef REG_ZERO_HARDWIRED_EN
    if (idx == 3'd0) return 16'd0;
`endif
    return regs[idx];
  endfunction

  function automatic logic [15:0] sext(input logic [15:0] word);
    return {{(16-IMM_W){word[IMM_W-1]}}, word[IMM_W-1:0]};
  endfunction

  assign in_op = instr[15:13];
  assign in_rd = instr[12:10];
  assign in_rs = instr[9:7];
  assign in_rt = instr[6:4];
  assign ir_op = ir[15:13];
  assign ir_rd = ir[12:10];

  assign instr_ready = (state == IDLE);
  assign mem_req     = (state == MEM);
  assign dbg_data    = rdreg(dbg_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = EXEC;
      EXEC:    state_nxt = (ir_op == OP_LW || ir_op == OP_SW) ? MEM : IDLE;
      MEM:     if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // beq compares R[rd] with R[rs]; immediate forms take sext(imm7) as operand b
  always_comb begin
    opnd_a = rdreg(in_rs);
    opnd_b = rdreg(in_rt);
    case (in_op)
      OP_ADDI, OP_LW, OP_SW: opnd_b = sext(instr);
      OP_BEQ: begin
        opnd_a = rdreg(in_rd);
        opnd_b = rdreg(in_rs);
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = alu_result;
    if (state == EXEC &&
        (ir_op == OP_RR0 || ir_op == OP_ADDI || ir_op == OP_RR2 || ir_op == OP_RR3)) begin
      wr_en = 1'b1;
    end else if (state == MEM && mem_ack && ir_op == OP_LW) begin
      wr_en   = 1'b1;
      wr_data = mem_rdata;
    end
`ifdef REG_ZERO_HARDWIRED_EN
    if (ir_rd == 3'd0) wr_en = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir            <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_opcode    <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      branch_valid  <= 1'b0;
      branch_taken  <= 1'b0;
      branch_offset <= '0;
      illegal       <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      branch_valid <= 1'b0;
      illegal      <= 1'b0;
      if (wr_en) regs[ir_rd] <= wr_data;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir         <= instr;
            alu_a      <= opnd_a;
            alu_b      <= opnd_b;
            alu_opcode <= in_op;
          end
        end
        EXEC: begin
          case (ir_op)
            OP_BEQ: begin
              branch_valid  <= 1'b1;
              branch_taken  <= alu_zero;
              branch_offset <= sext(ir);
            end
            OP_LW, OP_SW: begin
              mem_addr  <= alu_result;
              mem_we    <= (ir_op == OP_SW);
              mem_wdata <= rdreg(ir_rd);
            end
            OP_ILL:  illegal <= 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Multi-cycle issue/writeback stage directly upstream of the 16-bit ALU.
- Accepts one 16-bit instruction per handshake and reads an internal 8x16 register file.
- Drives registered a/b/opcode to the ALU, then consumes result/zero.
- Performs register writeback, the lw/sw memory handshake, and beq branch reporting.

Parameters:
- NREGS, 8, register count (index width is fixed at 3; NREGS must be 8).
- IMM_W, 7, immediate field width, sign-extended to 16 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr  in  16  [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [6:0] imm7
- instr_ready  out  1  stage can accept
- alu_a  out  16  ALU operand a (registered)
- alu_b  out  16  ALU operand b (registered)
- alu_opcode  out  3  ALU opcode (registered, equals op)
- alu_result  in  16  ALU result (combinational return)
- alu_zero  in  1  ALU zero flag
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = sw, 0 = lw
- mem_addr  out  16  alu_result captured at end of EXEC
- mem_wdata  out  16  R[rd] for sw
- mem_rdata  in  16  lw data, valid with mem_ack
- mem_ack  in  1  memory completion, single-cycle pulse
- branch_valid  out  1  one-cycle pulse on beq completion
- branch_taken  out  1  alu_zero captured for beq
- branch_offset  out  16  sext(imm7)
- illegal  out  1  one-cycle pulse for op 111
- dbg_addr  in  3  debug read index
- dbg_data  out  16  combinational R[dbg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - All registers cleared to 0; FSM goes to IDLE.
  - All outputs 0 except instr_ready=1.
  - Reset during MEM drops mem_req immediately and performs no writeback.
- FSM states: IDLE, EXEC, MEM.
  - IDLE: instr_ready=1. On instr_valid, latch instr, load the alu_* registers, go to EXEC.
  - EXEC (1 cycle): instr_ready=0.
    - op 000/010/011: R[rd] <= alu_result; go to IDLE.
    - op 001 (addi): R[rd] <= alu_result; go to IDLE.
    - op 100 (beq): branch_valid=1, branch_taken=alu_zero, branch_offset=sext(imm7); go to IDLE.
    - op 101/110: capture mem_addr=alu_result; go to MEM.
    - op 111: illegal=1; go to IDLE; no state change.
  - MEM: mem_req=1 until the cycle mem_ack=1.
    - lw: R[rd] <= mem_rdata on ack.
    - Either op: go to IDLE on ack. mem_req deasserts the cycle after ack.
    - mem_ack is ignored outside MEM.
- Operand selection:
  - 000/010/011: a=R[rs], b=R[rt].
  - 001/101/110: a=R[rs], b=sext(imm7).
  - 100: a=R[rd], b=R[rs].
- Register writes are plain 16-bit; no overflow flag and no saturation.
- Latency:
  - ALU op: accepted at edge N, written at edge N+1; next accept at edge N+2.
  - lw/sw: 2 + ack-wait cycles.
- dbg_data reads pre-write (old) data in the cycle a write occurs.
- instr_valid while instr_ready=0 is ignored; the upstream holds the instruction.

Optional Feature:
- Macro REG_ZERO_HARDWIRED_EN.
- Defined: R0 always reads 0 (operands and dbg_data), and writes to rd=0 are discarded.
- Undefined: R0 is an ordinary register.

Test Plan:
- Reset, then addi r1,r0,5; addi r2,r0,6; add r3,r1,r2 -> dbg r3=11; instr_ready low exactly one cycle per op.
- r1=4, addi r4,r1,-3 (imm7=0x7D) -> r4=1; alu_b=0xFFFD during EXEC.
- r1=10, r2=10, beq r1,r2,+4 -> branch_valid pulse, taken=1, offset=4. Then r2=-2 -> taken=0.
- r1=10, sw r1,10(r1) -> mem_req, mem_we=1, mem_addr=20, wdata=10; ack after 3 cycles -> mem_req falls the next cycle, ready returns.
- lw r5,10(r1) with rdata=0xBEEF: pull rst_n low while in MEM -> mem_req=0 immediately, r5=0, FSM in IDLE. Repeat without reset -> r5=0xBEEF.
- op 111 -> illegal pulse, no register changes. With REG_ZERO_HARDWIRED_EN, addi r0,r0,7 -> dbg r0=0; without it -> r0=7.
